// File: rtl/mmio_slot_fabric.sv
// MMIO slot fabric: decodes FPro-bus accesses onto N_SLOTS I/O cores, waits
// for a per-slot ready with a bounded timeout, registers read data and
// reports bus errors (illegal rd+wr, slot timeout) with a sticky flag.
module mmio_slot_fabric #(
  parameter int               N_SLOTS     = 8,
  parameter int               SLOT_AW     = 6,
  parameter int               REG_AW      = 5,
  parameter int               DW          = 32,
  parameter int               TIMEOUT     = 16,
  parameter logic [DW-1:0]    UNUSED_DATA = {DW{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mmio_cs,
  input  logic                  mmio_wr,
  input  logic                  mmio_rd,
  input  logic [20:0]           mmio_addr,
  input  logic [DW-1:0]         mmio_wr_data,
  output logic [DW-1:0]         mmio_rd_data,
  output logic                  mmio_ready,
  output logic [N_SLOTS-1:0]    slot_cs,
  output logic [N_SLOTS-1:0]    slot_rd,
  output logic [N_SLOTS-1:0]    slot_wr,
  output logic [REG_AW-1:0]     slot_reg_addr,
  output logic [DW-1:0]         slot_wr_data,
  input  logic [N_SLOTS*DW-1:0] slot_rd_data,
  input  logic [N_SLOTS-1:0]    slot_ready,
  output logic                  bus_err,
  output logic                  err_sticky,
  output logic [SLOT_AW-1:0]    err_slot,
  input  logic                  err_clr
);

  // Counter must be able to hold TIMEOUT itself.
  localparam int CW = $clog2(TIMEOUT + 1);
  // WAIT cycle on which the counter would reach TIMEOUT.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  // Slot count widened by one bit so N_SLOTS == 2**SLOT_AW still fits.
  localparam logic [SLOT_AW:0] N_SLOTS_W = (SLOT_AW + 1)'(N_SLOTS);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [SLOT_AW-1:0]  idx_q, idx_d;
  logic [REG_AW-1:0]   reg_q, reg_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic                err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                sticky_q, sticky_d;
  logic [SLOT_AW-1:0]  eslot_q, eslot_d;

  logic                req;
  logic [SLOT_AW-1:0]  req_idx;
  logic                req_mapped;
  logic [DW-1:0]       sel_data;
  logic                sel_rdy;

  assign req        = mmio_cs & (mmio_rd | mmio_wr);
  assign req_idx    = mmio_addr[REG_AW+SLOT_AW-1:REG_AW];
  assign req_mapped = ({1'b0, req_idx} < N_SLOTS_W);

  // Upper word-address bits are beyond the decoded slot/register fields.
  generate
    if (REG_AW + SLOT_AW < 21) begin : g_unused_addr
      logic unused_addr;
      assign unused_addr = ^mmio_addr[20:REG_AW+SLOT_AW];
    end
  endgenerate

  // Route the active slot's read data and ready; other slots are never looked at.
  always_comb begin
    sel_data = '0;
    sel_rdy  = 1'b0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (idx_q == SLOT_AW'(k)) begin
        sel_data = slot_rd_data[k*DW +: DW];
        sel_rdy  = slot_ready[k];
      end
    end
  end

  // One-hot slot strobes, combinational from state so reset drops them at once.
  always_comb begin
    slot_cs = '0;
    if (state_q == ACCESS) begin
      for (int k = 0; k < N_SLOTS; k++) begin
        slot_cs[k] = (idx_q == SLOT_AW'(k));
      end
    end
  end

  assign slot_rd = rd_q ? slot_cs : '0;
  assign slot_wr = rd_q ? '0 : slot_cs;

  // Next-state, capture and error bookkeeping.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    reg_d    = reg_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    // A clear request is overridden below if an error lands on the same edge.
    sticky_d = sticky_q & ~err_clr;
    eslot_d  = eslot_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = req_idx;
          reg_d   = mmio_addr[REG_AW-1:0];
          wdata_d = mmio_wr_data;
          rd_d    = mmio_rd;
          err_d   = 1'b0;
          if (mmio_rd && mmio_wr) begin
            // Illegal op: never touches a slot, completes with an error.
            state_d  = DONE;
            err_d    = 1'b1;
            rdata_d  = UNUSED_DATA;
            sticky_d = 1'b1;
            eslot_d  = req_idx;
          end else if (!req_mapped) begin
            // Unmapped slot: quiet completion with filler data.
            state_d = DONE;
            rdata_d = UNUSED_DATA;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        cnt_d = '0;
        if (sel_rdy) begin
          state_d = DONE;
          if (rd_q) rdata_d = sel_data;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Ready is checked first so it wins over a coincident timeout.
        if (sel_rdy) begin
          state_d = DONE;
          if (rd_q) rdata_d = sel_data;
        end else if (cnt_q == TO_LAST) begin
          state_d  = DONE;
          err_d    = 1'b1;
          rdata_d  = UNUSED_DATA;
          sticky_d = 1'b1;
          eslot_d  = idx_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; everything observable clears on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      reg_q    <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      sticky_q <= 1'b0;
      eslot_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      reg_q    <= reg_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      sticky_q <= sticky_d;
      eslot_q  <= eslot_d;
    end
  end

  assign mmio_ready    = (state_q == DONE);
  assign bus_err       = (state_q == DONE) & err_q;
  assign mmio_rd_data  = rdata_q;
  assign slot_reg_addr = reg_q;
  assign slot_wr_data  = wdata_q;
  assign err_sticky    = sticky_q;
  assign err_slot      = eslot_q;

endmodule

// File: tb/tb_mmio_slot_fabric.sv
// Bench for mmio_slot_fabric: a table of accesses with their expected
// latency, error and read data, checked through a scoreboard queue, plus
// hand-written sequences for error clearing and reset during an access.
module tb_mmio_slot_fabric;

  localparam int NS = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           mmio_cs = 1'b0, mmio_wr = 1'b0, mmio_rd = 1'b0;
  logic [20:0]    mmio_addr = '0;
  logic [31:0]    mmio_wr_data = '0;
  logic [31:0]    mmio_rd_data;
  logic           mmio_ready;
  logic [NS-1:0]  slot_cs, slot_rd, slot_wr;
  logic [4:0]     slot_reg_addr;
  logic [31:0]    slot_wr_data;
  logic [NS*32-1:0] slot_rd_data = '0;
  logic [NS-1:0]  slot_ready = '0;
  logic           bus_err, err_sticky;
  logic [5:0]     err_slot;
  logic           err_clr = 1'b0;

  mmio_slot_fabric #(.N_SLOTS(NS), .SLOT_AW(6), .REG_AW(5), .DW(32), .TIMEOUT(TO),
                     .UNUSED_DATA(32'hFFFF_FFFF)) dut (
    .clk(clk), .reset(reset), .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data),
    .mmio_ready(mmio_ready), .slot_cs(slot_cs), .slot_rd(slot_rd), .slot_wr(slot_wr),
    .slot_reg_addr(slot_reg_addr), .slot_wr_data(slot_wr_data), .slot_rd_data(slot_rd_data),
    .slot_ready(slot_ready), .bus_err(bus_err), .err_sticky(err_sticky), .err_slot(err_slot),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // dly: slot_ready asserted dly cycles after the ACCESS cycle; -1 = never.
  typedef struct {
    logic        rd;
    logic        wr;
    int          slot;
    int          regad;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] sdata;
    logic        strb;
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          slot;
    int          regad;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[12];
  int   n_chk = 0;
  int   n_pass = 0;
  int   stray_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    exp_t        e;
    int          cyc;
    int          nstrb;
    bit          good;
    bit          done;
    logic [NS-1:0] sel;
    @(negedge clk);
    chk({tag, "_idle_ready"}, 64'(mmio_ready), 64'd0);
    sel = (v.slot < NS) ? NS'(1 << v.slot) : '0;
    for (int k = 0; k < NS; k++)
      slot_rd_data[k*32 +: 32] = (k == v.slot) ? v.sdata : (32'h1111_0000 + 32'(k));
    mmio_cs      = 1'b1;
    mmio_rd      = v.rd;
    mmio_wr      = v.wr;
    mmio_addr    = 21'(v.slot * 32 + v.regad);
    mmio_wr_data = v.wdata;
    slot_ready   = ~sel;
    e.lat = v.lat; e.err = v.err; e.rdata = v.rdata;
    e.slot = v.slot; e.regad = v.regad; e.wdata = v.wdata;
    sb.push_back(e);
    cyc = 0; nstrb = 0; good = 1'b1; done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      mmio_cs = 1'b0; mmio_rd = 1'b0; mmio_wr = 1'b0;
      slot_ready = (v.dly >= 0 && cyc == 1 + v.dly) ? '1 : ~sel;
      if (slot_cs != 0 || slot_rd != 0 || slot_wr != 0) begin
        nstrb++;
        if (!(cyc == 1 && slot_cs == sel && slot_rd == (v.rd ? sel : '0) &&
              slot_wr == (v.wr ? sel : '0))) good = 1'b0;
      end
      if (bus_err && !mmio_ready) stray_err++;
      if (mmio_ready) begin
        done = 1'b1;
        e = sb.pop_front();
        chk({tag, "_latency"}, 64'(cyc), 64'(e.lat));
        chk({tag, "_bus_err"}, 64'(bus_err), 64'(e.err));
        chk({tag, "_rd_data"}, 64'(mmio_rd_data), 64'(e.rdata));
        chk({tag, "_reg_addr"}, 64'(slot_reg_addr), 64'(e.regad));
        chk({tag, "_wr_data"}, 64'(slot_wr_data), 64'(e.wdata));
        if (e.err) begin
          chk({tag, "_err_sticky"}, 64'(err_sticky), 64'd1);
          chk({tag, "_err_slot"}, 64'(err_slot), 64'(e.slot));
        end
      end
    end
    if (!done) begin
      chk({tag, "_ready_timeout"}, 64'd0, 64'd1);
      void'(sb.pop_front());
    end
    chk({tag, "_strobes"}, {62'(nstrb), 1'b0, good}, {62'(v.strb ? 1 : 0), 1'b0, 1'b1});
    slot_ready = '0;
  endtask

  initial begin
    int bad;
    // rd wr slot reg wdata dly sdata strb lat err rdata
    tbl[0]  = '{1'b1, 1'b0, 2,  3,  32'h0,         0, 32'hA5A5_0001, 1'b1, 2,      1'b0, 32'hA5A5_0001};
    tbl[1]  = '{1'b0, 1'b1, 5,  7,  32'hDEAD_BEEF, 4, 32'h0,         1'b1, 6,      1'b0, 32'hA5A5_0001};
    tbl[2]  = '{1'b1, 1'b0, 40, 2,  32'h0,         0, 32'h5555_5555, 1'b0, 1,      1'b0, 32'hFFFF_FFFF};
    tbl[3]  = '{1'b1, 1'b0, 1,  4,  32'h0,        -1, 32'h0101_0101, 1'b1, TO + 2, 1'b1, 32'hFFFF_FFFF};
    tbl[4]  = '{1'b1, 1'b0, 3,  9,  32'h0,        TO, 32'h3333_CAFE, 1'b1, TO + 2, 1'b0, 32'h3333_CAFE};
    tbl[5]  = '{1'b1, 1'b1, 6,  1,  32'h0000_00AA, 0, 32'h6666_0000, 1'b0, 1,      1'b1, 32'hFFFF_FFFF};
    tbl[6]  = '{1'b1, 1'b0, 0,  31, 32'h0,         1, 32'h1234_5678, 1'b1, 3,      1'b0, 32'h1234_5678};
    tbl[7]  = '{1'b1, 1'b0, 7,  0,  32'h0,         2, 32'h7777_0007, 1'b1, 4,      1'b0, 32'h7777_0007};
    tbl[8]  = '{1'b0, 1'b1, 0,  5,  32'hC0DE_0000, TO + 1, 32'h0,   1'b1, TO + 2, 1'b1, 32'hFFFF_FFFF};
    tbl[9]  = '{1'b1, 1'b0, 63, 31, 32'h0,         0, 32'h0,         1'b0, 1,      1'b0, 32'hFFFF_FFFF};
    tbl[10] = '{1'b0, 1'b1, 6,  12, 32'h0BAD_F00D, 0, 32'h0,         1'b1, 2,      1'b0, 32'hFFFF_FFFF};
    tbl[11] = '{1'b1, 1'b0, 6,  12, 32'h0,         3, 32'h6666_ABCD, 1'b1, 5,      1'b0, 32'h6666_ABCD};

    #1 reset = 1'b0;
    #1;
    chk("rst_ready", 64'(mmio_ready), 64'd0);
    chk("rst_cs", 64'(slot_cs), 64'd0);
    chk("rst_bus_err", 64'(bus_err), 64'd0);
    chk("rst_rd_data", 64'(mmio_rd_data), 64'd0);
    chk("rst_sticky", 64'(err_sticky), 64'd0);
    chk("rst_err_slot", 64'(err_slot), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // Last error was the write timeout on slot 0; clear it.
    @(negedge clk);
    chk("sticky_held", 64'(err_sticky), 64'd1);
    chk("err_slot_held", 64'(err_slot), 64'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("sticky_cleared", 64'(err_sticky), 64'd0);
    chk("err_slot_kept", 64'(err_slot), 64'd0);

    // Clear held high across an illegal access: the error must still set the flag.
    err_clr = 1'b1;
    run_vec('{1'b1, 1'b1, 4, 2, 32'h0, 0, 32'h0, 1'b0, 1, 1'b1, 32'hFFFF_FFFF}, "setwins");
    err_clr = 1'b0;
    @(negedge clk);
    chk("setwins_hold", 64'(err_sticky), 64'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("setwins_clear", 64'(err_sticky), 64'd0);

    // Reset in the middle of a wait on slot 4 abandons the access.
    @(negedge clk);
    slot_rd_data[4*32 +: 32] = 32'h4444_0004;
    mmio_cs = 1'b1; mmio_rd = 1'b1; mmio_addr = 21'(4 * 32 + 1);
    @(negedge clk);
    mmio_cs = 1'b0; mmio_rd = 1'b0;
    chk("rstw_access_cs", 64'(slot_cs), 64'h10);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstw_cs", 64'(slot_cs), 64'd0);
    chk("rstw_ready", 64'(mmio_ready), 64'd0);
    chk("rstw_rd_data", 64'(mmio_rd_data), 64'd0);
    slot_ready = 8'h10;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mmio_ready || slot_cs != 0 || bus_err) bad++;
    end
    chk("rstw_quiet", 64'(bad), 64'd0);
    slot_ready = '0;
    run_vec(tbl[0], "after_rst");

    chk("stray_bus_err", 64'(stray_err), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Absolute time bound in case a wait ever stops advancing.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
